// File: rtl/sobel_row_stream.sv
// Streaming 3x3 Sobel row filter: one row in, one row of (WIDTH-2) magnitudes out, 2-stage pipeline.
// Optional build macro SOBEL_THRESH_EN turns the saturated magnitude into a binary edge map against thresh.
module sobel_row_stream #(
  parameter int WIDTH = 5,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [WIDTH*PIX_W-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(WIDTH-2)*PIX_W-1:0] out_data
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [PIX_W-1:0]           thresh
`endif
);

  localparam int COLS  = WIDTH - 2;
  localparam int SW    = PIX_W + 3;
  localparam int ROW_W = WIDTH * PIX_W;
  localparam int OUT_W = COLS * PIX_W;
  localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;

  fill_t state, state_nxt;

  logic en;
  logic accept;
  logic issue;

  // The row shifted out of r1 is never read again, so only the two most recent rows are stored.
  logic [ROW_W-1:0] r1;
  logic [ROW_W-1:0] r2;

  logic signed [SW-1:0] gx_a [COLS];
  logic signed [SW-1:0] gy_a [COLS];
  logic signed [SW-1:0] gx_p1 [COLS];
  logic signed [SW-1:0] gy_p1 [COLS];
  logic                 vld_p1;

  logic [OUT_W-1:0] out_b;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({3'b000, p});
  endfunction

  function automatic logic [SW-1:0] abs_s(input logic signed [SW-1:0] v);
    logic [SW-1:0] r;
    r = v[SW-1] ? -v : v;
    return r;
  endfunction

`ifdef SOBEL_THRESH_EN
  function automatic logic [PIX_W-1:0] shape(input logic [SW-1:0] mag,
                                             input logic [PIX_W-1:0] th);
    return (mag >= {3'b000, th}) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  endfunction
`else
  function automatic logic [PIX_W-1:0] shape(input logic [SW-1:0] mag);
    return (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
  endfunction
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && !in_sof && (state == TWO || state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A start-of-frame row always becomes row one of the new window history.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_sof) begin
        state_nxt = ONE;
      end else begin
        case (state)
          EMPTY:   state_nxt = ONE;
          ONE:     state_nxt = TWO;
          TWO:     state_nxt = FULL;
          default: state_nxt = FULL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 <= '0;
      r2 <= '0;
    end else if (accept) begin
      r1 <= r2;
      r2 <= in_data;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [SW-1:0] tl, tm, tr, ml, mr, bl, bm, br;
    assign tl = ext(r1[c*PIX_W +: PIX_W]);
    assign tm = ext(r1[(c+1)*PIX_W +: PIX_W]);
    assign tr = ext(r1[(c+2)*PIX_W +: PIX_W]);
    assign ml = ext(r2[c*PIX_W +: PIX_W]);
    assign mr = ext(r2[(c+2)*PIX_W +: PIX_W]);
    assign bl = ext(in_data[c*PIX_W +: PIX_W]);
    assign bm = ext(in_data[(c+1)*PIX_W +: PIX_W]);
    assign br = ext(in_data[(c+2)*PIX_W +: PIX_W]);
    assign gx_a[c] = (tr + (mr <<< 1) + br) - (tl + (ml <<< 1) + bl);
    assign gy_a[c] = (bl + (bm <<< 1) + br) - (tl + (tm <<< 1) + tr);
  end

  // Stage A: signed gradients of the issued window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (en && issue) begin
      gx_p1 <= gx_a;
      gy_p1 <= gy_a;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_mag
    logic [SW-1:0] mag;
    assign mag = abs_s(gx_p1[c]) + abs_s(gy_p1[c]);
`ifdef SOBEL_THRESH_EN
    assign out_b[c*PIX_W +: PIX_W] = shape(mag, thresh);
`else
    assign out_b[c*PIX_W +: PIX_W] = shape(mag);
`endif
  end

  // Stage B: magnitude, saturated or thresholded, into the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= out_b;
      end
    end
  end

endmodule

// File: tb/tb_sobel_row_stream.sv
// Scoreboard bench for sobel_row_stream: directed rows, hand-computed magnitudes queued, monitor compares.
module tb_sobel_row_stream;

  localparam int WIDTH = 5;
  localparam int PIX_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [39:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
`ifdef SOBEL_THRESH_EN
  logic [7:0]  thresh;
`endif

  always #5 clk = ~clk;

  sobel_row_stream #(.WIDTH(WIDTH), .PIX_W(PIX_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sof(in_sof),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh(thresh)
`endif
  );

  logic [23:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] shape(input int mag);
`ifdef SOBEL_THRESH_EN
    return (mag >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return (mag > 255) ? 8'hFF : 8'(mag);
`endif
  endfunction

  function automatic logic [39:0] row(input int p0, input int p1, input int p2,
                                      input int p3, input int p4);
    return {8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  function automatic logic [39:0] ramp(input int off);
    return row(off, 10 + off, 20 + off, 30 + off, 40 + off);
  endfunction

  task automatic expect3(input int m0, input int m1, input int m2);
    exp_q.push_back({shape(m2), shape(m1), shape(m0)});
  endtask

  task automatic send(input logic [39:0] d, input logic sof);
    int n = 0;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic send_test1(input logic sof);
    send(row(60, 82, 71, 82, 60), sof);
    send(row(121, 174, 216, 174, 121), 1'b0);
    send(row(88, 127, 165, 127, 88), 1'b0);
  endtask

  // Monitor: compare every delivered beat against the scoreboard, check stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && out_valid)
        check("stall_hold", 64'(out_data), 64'(prev_data));
      if (out_valid && !out_ready)
        check("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h, expected no output", out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef SOBEL_THRESH_EN
    thresh    = 8'd100;
`endif
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reference rows: raw magnitudes 490, 278, 490
    expect3(490, 278, 490);
    send_test1(1'b1);
    drain("drain_test1");

    // Horizontal ramp: Gx = 80, Gy = 0
    expect3(80, 80, 80);
    expect3(80, 80, 80);
    for (int i = 0; i < 4; i++) send(ramp(0), i == 0);
    drain("drain_ramp");

    expect3(0, 0, 0);
    for (int i = 0; i < 3; i++) send(row(10, 10, 10, 10, 10), i == 0);
    drain("drain_flat");

    // Ramp with row offsets 0,1,3,6,10,15: mag = 80 + 4*(o_bottom - o_top)
    expect3(92, 92, 92);
    expect3(100, 100, 100);
    expect3(108, 108, 108);
    expect3(116, 116, 116);
    fork
      begin
        send(ramp(0), 1'b1);
        send(ramp(1), 1'b0);
        send(ramp(3), 1'b0);
        send(ramp(6), 1'b0);
        send(ramp(10), 1'b0);
        send(ramp(15), 1'b0);
      end
      begin
        int n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("stall_out_valid_seen", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // New frame on row 5: rows 1-4 drain, next output only from rows 5-7
    expect3(92, 92, 92);
    expect3(100, 100, 100);
    expect3(490, 278, 490);
    send(ramp(0), 1'b1);
    send(ramp(1), 1'b0);
    send(ramp(3), 1'b0);
    send(ramp(6), 1'b0);
    send_test1(1'b1);
    drain("drain_sof");

    // Asynchronous reset between edges while stage A holds a window
    for (int i = 0; i < 4; i++) send(ramp(0), i == 0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(row(60, 82, 71, 82, 60), 1'b0);
    send(row(121, 174, 216, 174, 121), 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_output", 64'(exp_q.size()), 64'd0);
    expect3(490, 278, 490);
    send(row(88, 127, 165, 127, 88), 1'b0);
    drain("drain_post_rst");

`ifdef SOBEL_THRESH_EN
    thresh = 8'd100;
    expect3(80, 80, 80);
    for (int i = 0; i < 3; i++) send(ramp(0), i == 0);
    drain("drain_thresh100");
    thresh = 8'd80;
    expect3(80, 80, 80);
    for (int i = 0; i < 3; i++) send(ramp(0), i == 0);
    drain("drain_thresh80");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
